// File: rtl/gps_pkg.sv
// Shared widths, FSM encoding and slot-unpack helpers for the acquisition-to-tracking handoff.
package gps_pkg;
    localparam int NUM_SLOTS = 4;
    localparam int PRN_W     = 5;
    localparam int CODE_W    = 11;
    localparam int CARR_W    = 32;
    localparam int PTR_W     = 16;
    localparam int IDX_W     = 2;
    localparam int CNT_W     = 3;

    localparam logic [PRN_W-1:0] PRN_NONE = '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_OFFER  = 2'd2,
        ST_FINISH = 2'd3
    } handoff_state_t;

    function automatic logic [PRN_W-1:0] slot_prn(input logic [NUM_SLOTS*PRN_W-1:0] bus,
                                                   input logic [IDX_W-1:0] idx);
        return bus[int'(idx)*PRN_W +: PRN_W];
    endfunction

    function automatic logic [CODE_W-1:0] slot_code(input logic [NUM_SLOTS*CODE_W-1:0] bus,
                                                     input logic [IDX_W-1:0] idx);
        return bus[int'(idx)*CODE_W +: CODE_W];
    endfunction

    function automatic logic [CARR_W-1:0] slot_carr(input logic [NUM_SLOTS*CARR_W-1:0] bus,
                                                     input logic [IDX_W-1:0] idx);
        return bus[int'(idx)*CARR_W +: CARR_W];
    endfunction
endpackage

// File: rtl/acq_track_handoff_dup_filter.sv
// Remembers the PRNs dispatched in the current handoff and flags a repeat of any of them.
module handoff_dup_filter
    import gps_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             record,
    input  logic [PRN_W-1:0] record_prn,
    input  logic [PRN_W-1:0] query_prn,
    output logic             seen
);
    logic [PRN_W-1:0]     prn_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] used_q;
    logic [IDX_W-1:0]     wr_ptr;

    always_comb begin
        seen = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (used_q[i] && (prn_q[i] == query_prn)) seen = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            used_q <= '0;
            wr_ptr <= '0;
        end else if (clear) begin
            used_q <= '0;
            wr_ptr <= '0;
        end else if (record) begin
            prn_q[wr_ptr]  <= record_prn;
            used_q[wr_ptr] <= 1'b1;
            wr_ptr         <= wr_ptr + IDX_W'(1);
        end
    end
endmodule

// File: rtl/acq_track_handoff.sv
// Snapshots acquisition results on completion and hands surviving slots to tracking one at a time.
//   state     | meaning
//   ST_IDLE   | waiting for a rising edge on acq_complete
//   ST_SCAN   | one cycle per slot: skip empty/duplicate or load an offer
//   ST_OFFER  | trk_valid held until the tracker takes the record
//   ST_FINISH | done pulse visible, returning to idle
module acq_track_handoff
    import gps_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        acq_complete,
    input  logic [NUM_SLOTS*PRN_W-1:0]  acq_prn,
    input  logic [NUM_SLOTS*CODE_W-1:0] acq_code_phase,
    input  logic [NUM_SLOTS*CARR_W-1:0] acq_carr_phase,
    input  logic [PTR_W-1:0]            acq_epoch_ptr,
    output logic                        trk_valid,
    input  logic                        trk_ready,
    output logic [IDX_W-1:0]            trk_slot,
    output logic [PRN_W-1:0]            trk_prn,
    output logic [CODE_W-1:0]           trk_code_phase,
    output logic [CARR_W-1:0]           trk_carr_phase,
    output logic [PTR_W-1:0]            trk_start_ptr,
    output logic                        busy,
    output logic                        done,
    output logic [CNT_W-1:0]            dispatch_cnt,
    output logic [NUM_SLOTS-1:0]        skip_mask,
    output logic                        overrun
);
    handoff_state_t              state;
    logic                        acq_complete_q;
    logic [NUM_SLOTS*PRN_W-1:0]  sh_prn;
    logic [NUM_SLOTS*CODE_W-1:0] sh_code;
    logic [NUM_SLOTS*CARR_W-1:0] sh_carr;
    logic [PTR_W-1:0]            sh_epoch;
    logic [IDX_W-1:0]            idx;

    logic             start, seen, last_slot, accept, clear_seen;
    logic [PRN_W-1:0] cur_prn;
    logic [CODE_W-1:0] cur_code;

    assign start      = acq_complete & ~acq_complete_q;
    assign cur_prn    = slot_prn(sh_prn, idx);
    assign cur_code   = slot_code(sh_code, idx);
    assign last_slot  = (idx == IDX_W'(NUM_SLOTS - 1));
    assign accept     = (state == ST_OFFER) && trk_valid && trk_ready;
    assign clear_seen = (state == ST_IDLE) && start;

    handoff_dup_filter u_dup_filter (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear_seen),
        .record     (accept),
        .record_prn (trk_prn),
        .query_prn  (cur_prn),
        .seen       (seen)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= ST_IDLE;
            acq_complete_q <= 1'b0;
            sh_prn         <= '0;
            sh_code        <= '0;
            sh_carr        <= '0;
            sh_epoch       <= '0;
            idx            <= '0;
            trk_valid      <= 1'b0;
            trk_slot       <= '0;
            trk_prn        <= '0;
            trk_code_phase <= '0;
            trk_carr_phase <= '0;
            trk_start_ptr  <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            dispatch_cnt   <= '0;
            skip_mask      <= '0;
            overrun        <= 1'b0;
        end else begin
            acq_complete_q <= acq_complete;
            done           <= 1'b0;
            // Any edge outside IDLE, including the FINISH cycle, is dropped and flagged.
            if (start && (state != ST_IDLE)) overrun <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sh_prn       <= acq_prn;
                        sh_code      <= acq_code_phase;
                        sh_carr      <= acq_carr_phase;
                        sh_epoch     <= acq_epoch_ptr;
                        dispatch_cnt <= '0;
                        skip_mask    <= '0;
                        idx          <= '0;
                        busy         <= 1'b1;
                        state        <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if ((cur_prn == PRN_NONE) || seen) begin
                        skip_mask[idx] <= 1'b1;
                        if (last_slot) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_FINISH;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        trk_slot       <= idx;
                        trk_prn        <= cur_prn;
                        trk_code_phase <= cur_code;
                        trk_carr_phase <= slot_carr(sh_carr, idx);
                        trk_start_ptr  <= sh_epoch + PTR_W'(cur_code);
                        trk_valid      <= 1'b1;
                        state          <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (trk_ready) begin
                        trk_valid    <= 1'b0;
                        dispatch_cnt <= dispatch_cnt + CNT_W'(1);
                        if (last_slot) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_FINISH;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= ST_SCAN;
                        end
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/acq_track_handoff.md
Name: acq_track_handoff

Overview:
- Sits directly downstream of the acquisition engine and upstream of the tracking channels.
- On each rising edge of the engine's completion flag, it snapshots the four per-slot results (PRN ID, code phase, carrier phase).
- It filters out empty and duplicate slots, then dispatches the survivors one at a time to the tracker over a valid/ready handshake.
- Each dispatched record carries a sample-memory start pointer aligned to the acquired code phase.

Parameters:
- NUM_SLOTS, 4, acquisition result slots per run
- PRN_W, 5, PRN ID width (0 = no satellite)
- CODE_W, 11, code phase width in samples
- CARR_W, 32, carrier phase/NCO word width
- PTR_W, 16, tracker sample-memory read-pointer width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- acq_complete  in  1  acquisition done level; a rising edge starts a handoff
- acq_prn  in  NUM_SLOTS*PRN_W  packed PRN IDs; slot 0 in the LSBs
- acq_code_phase  in  NUM_SLOTS*CODE_W  packed code phases
- acq_carr_phase  in  NUM_SLOTS*CARR_W  packed carrier phase words
- acq_epoch_ptr  in  PTR_W  read pointer of the first sample of the acquired ms
- trk_valid  out  1  dispatch record valid
- trk_ready  in  1  tracker accepts the record
- trk_slot  out  2  source slot index
- trk_prn  out  PRN_W  PRN ID
- trk_code_phase  out  CODE_W  code phase
- trk_carr_phase  out  CARR_W  carrier phase word
- trk_start_ptr  out  PTR_W  tracker start read pointer
- busy  out  1  handoff in progress
- done  out  1  one-cycle pulse at end of handoff
- dispatch_cnt  out  3  records accepted in the last handoff
- skip_mask  out  NUM_SLOTS  slots skipped in the last handoff
- overrun  out  1  sticky: a completion edge arrived while busy

Behaviour:
- Reset (reset==0 at a clk edge):
  - All outputs go to 0, FSM goes to IDLE, internal acq_complete delay register is cleared.
  - Reset mid-handoff abandons it with no done pulse.
  - The first cycle after reset sees acq_complete "previous" as 0, so a level held high through reset triggers one handoff.
- Edge detect: start = acq_complete & ~acq_complete_q, with acq_complete_q registered every cycle.
- FSM states: IDLE, SCAN, OFFER, FINISH.
- IDLE:
  - On start, latch all acq_* buses and acq_epoch_ptr into shadow registers.
  - Clear dispatch_cnt and skip_mask; set idx=0, busy=1; go to SCAN.
  - Later input changes do not affect the latched set.
- SCAN (exactly one cycle per slot), for slot idx:
  - The slot is skipped if prn==0, or if prn equals a PRN already dispatched in this handoff. Only dispatched slots count for duplicates; skipped slots do not.
  - Skip: set skip_mask[idx]. If idx==NUM_SLOTS-1 go to FINISH, else idx++ and stay in SCAN.
  - Otherwise: load the trk_* output registers, assert trk_valid, go to OFFER.
- Start pointer: trk_start_ptr = (epoch_ptr + zero-extended code_phase) mod 2^PTR_W. Wraps silently.
- OFFER:
  - trk_valid and all trk_* outputs stay stable until trk_valid & trk_ready at a clk edge.
  - On acceptance: trk_valid=0, dispatch_cnt++, PRN recorded as dispatched. Then go to FINISH if this was the last slot, else idx++ and go to SCAN.
  - trk_ready already high when trk_valid rises gives a one-cycle handshake.
  - trk_ready is ignored in every state other than OFFER.
- FINISH: done=1 for one cycle, busy=0, return to IDLE. dispatch_cnt and skip_mask hold until the next start.
- Latency:
  - First trk_valid is 2 cycles after the start edge when slot 0 is valid (IDLE capture, then SCAN).
  - Each skipped slot adds 1 cycle.
  - With all slots skipped, done pulses NUM_SLOTS+1 cycles after the start edge.
- Start while busy:
  - The edge is ignored (no re-latch) and overrun sets to 1.
  - overrun clears only on reset.
  - A start on the same cycle as FINISH is also ignored and sets overrun.

Decomposition:
- Shared package (gps_pkg):
  - PRN_W, CODE_W, CARR_W, PTR_W, NUM_SLOTS.
  - PRN_NONE=0.
  - FSM state encoding.
  - Slot-unpack helper functions for the packed buses.
- One natural sub-module: handoff_dup_filter. It holds a combinational PRN-seen check against a NUM_SLOTS-entry dispatched-PRN register file, with a clear input and a record input.

Test Plan:
1. PRNs {7,12,19,3}, code phases {0,100,1999,500}, epoch_ptr=0x0100, trk_ready held 1:
   - Records dispatched on 4 consecutive handshakes, first trk_valid 2 cycles after the edge.
   - start_ptrs = 0x0100, 0x0164, 0x08CF, 0x02F4.
   - dispatch_cnt=4, skip_mask=0000, done pulses once.
2. PRNs {5,0,5,9}:
   - Slots 0 and 3 dispatched; skip_mask=0110; dispatch_cnt=2.
3. epoch_ptr=0xFF00, code phase 0x0200:
   - trk_start_ptr=0x0100 (wrap).
4. trk_ready held 0 for 10 cycles on slot 0:
   - trk_valid and all trk_* stable for 10 cycles; acceptance on the first ready.
5. Second acq_complete edge while OFFER is pending:
   - Latched data unchanged, overrun=1 and stays 1 through the next handoff.
6. Reset low in OFFER:
   - Next cycle all outputs 0, no done pulse.
   - acq_complete held high gives a new handoff after reset releases.
7. All PRNs 0:
   - No trk_valid, skip_mask=1111, done 5 cycles after the edge.
